// File: rtl/time_disp_pkg.sv
// Shared definitions for the MM.SS seven-segment display path: converter
// state encoding, segment patterns, digit slot numbering and the
// double-dabble iteration helper.
package time_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } conv_state_t;

    // Active-high segment patterns {g,f,e,d,c,b,a} for decimal digits 0..9
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // A 6-bit binary value needs one shift per input bit
    localparam int BCD_ITERS = 6;

    // Display slot numbering, right to left on the board
    localparam logic [1:0] IDX_SEC_O = 2'd0;
    localparam logic [1:0] IDX_SEC_T = 2'd1;
    localparam logic [1:0] IDX_MIN_O = 2'd2;
    localparam logic [1:0] IDX_MIN_T = 2'd3;

    // One double-dabble iteration on {tens[13:10], ones[9:6], binary[5:0]}:
    // bump any BCD nibble that is 5 or more by 3, then shift left once.
    function automatic logic [13:0] dabble_step(input logic [13:0] v);
        logic [13:0] a;
        a = v;
        if (a[9:6] >= 4'd5) begin
            a[9:6] = a[9:6] + 4'd3;
        end
        if (a[13:10] >= 4'd5) begin
            a[13:10] = a[13:10] + 4'd3;
        end
        return {a[12:0], 1'b0};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-high seven-segment pattern. Codes above 9 never come
// out of the converter, but are shown blank rather than as garbage.
module seg7_decode
    import time_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pattern
);

    // Table lookup, blank for non-decimal codes
    always_comb begin
        pattern = SEG_BLANK;
        case (bcd)
            4'd0: pattern = SEG_DIGIT[0];
            4'd1: pattern = SEG_DIGIT[1];
            4'd2: pattern = SEG_DIGIT[2];
            4'd3: pattern = SEG_DIGIT[3];
            4'd4: pattern = SEG_DIGIT[4];
            4'd5: pattern = SEG_DIGIT[5];
            4'd6: pattern = SEG_DIGIT[6];
            4'd7: pattern = SEG_DIGIT[7];
            4'd8: pattern = SEG_DIGIT[8];
            4'd9: pattern = SEG_DIGIT[9];
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_display_mux.sv
// Four-digit MM.SS multiplexed display driver. Binary seconds/minutes are
// snapshotted once per frame and converted to BCD with an iterative
// double-dabble engine, so digits only change between full scans.
module time_display_mux
    import time_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 2;
    localparam logic [CW-1:0] COUNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [2:0]    ITER_LAST  = 3'(BCD_ITERS - 1);

    logic [CW-1:0] refresh_count;
    logic [1:0]    idx;
    logic          tick;
    logic          frame_start;

    conv_state_t   state;
    logic [2:0]    iter;
    logic [13:0]   sec_sr;
    logic [13:0]   min_sr;

    logic [3:0]    sec_o;
    logic [3:0]    sec_t;
    logic [3:0]    min_o;
    logic [3:0]    min_t;

    logic [3:0]    cur_digit;
    logic [6:0]    cur_pattern;
    logic [3:0]    an_hi;
    logic [6:0]    seg_hi;
    logic          dp_hi;

    assign tick        = (refresh_count == COUNT_LAST);
    assign frame_start = tick && (idx == IDX_MIN_T);

    // Dwell counter and digit index that together scan the four digits
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_count <= '0;
            idx           <= IDX_SEC_O;
        end else if (tick) begin
            refresh_count <= '0;
            idx           <= idx + 2'd1;
        end else begin
            refresh_count <= refresh_count + 1'b1;
        end
    end

    // Converter: snapshot at frame start, six dabble steps, then publish
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            iter   <= '0;
            sec_sr <= '0;
            min_sr <= '0;
            sec_o  <= '0;
            sec_t  <= '0;
            min_o  <= '0;
            min_t  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        sec_sr <= {8'd0, sec};
                        min_sr <= {8'd0, min};
                        iter   <= '0;
                        state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    sec_sr <= dabble_step(sec_sr);
                    min_sr <= dabble_step(min_sr);
                    iter   <= iter + 3'd1;
                    if (iter == ITER_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    min_t <= min_sr[13:10];
                    min_o <= min_sr[9:6];
                    sec_t <= sec_sr[13:10];
                    sec_o <= sec_sr[9:6];
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pick the digit for the slot currently being scanned
    always_comb begin
        cur_digit = sec_o;
        case (idx)
            IDX_SEC_O: cur_digit = sec_o;
            IDX_SEC_T: cur_digit = sec_t;
            IDX_MIN_O: cur_digit = min_o;
            IDX_MIN_T: cur_digit = min_t;
            default:   cur_digit = sec_o;
        endcase
    end

    seg7_decode u_decode (
        .bcd     (cur_digit),
        .pattern (cur_pattern)
    );

    // Active-high view of the next pin values, blanked on request
    always_comb begin
        an_hi  = 4'b0000;
        seg_hi = SEG_BLANK;
        dp_hi  = 1'b0;
        if (!blank) begin
            an_hi        = 4'b0000;
            an_hi[idx]   = 1'b1;
            seg_hi       = cur_pattern;
            dp_hi        = (idx == IDX_MIN_O);
        end
    end

    // Registered pins with board polarity applied
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= SEG_ACTIVE_LOW ? 4'b1111 : 4'b0000;
            seg <= SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
            dp  <= SEG_ACTIVE_LOW;
        end else begin
            an  <= SEG_ACTIVE_LOW ? ~an_hi  : an_hi;
            seg <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
            dp  <= SEG_ACTIVE_LOW ? ~dp_hi  : dp_hi;
        end
    end

endmodule

// File: doc/time_display_mux.md
Name: time_display_mux

Overview:
- Downstream consumer of the seconds/minutes counter.
- Converts 6-bit binary sec/min to BCD with an iterative double-dabble engine.
- Time-multiplexes four seven-segment digits (MM.SS) on a board display.
- Displayed values change only at frame boundaries, so the display never tears.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit is driven; legal minimum is 3.
- SEG_ACTIVE_LOW, 1: 1 means an, seg and dp are active-low; 0 means active-high.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- sec  in  6  binary seconds from the counter, 0..63 accepted
- min  in  6  binary minutes from the counter, 0..63 accepted
- blank  in  1  1 turns all digits off; counters keep running
- an  out  4  digit enables; an[0] = seconds ones, an[3] = minutes tens
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point; lit only on digit 2 (separates MM.SS)

Behaviour:
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps. tick = (count == REFRESH_DIV-1).
- Digit index: 2-bit, increments on tick, wraps 3 to 0.
- frame_start = tick AND index == 3.
- Converter FSM states: IDLE, CONV, DONE.
  - IDLE -> CONV on frame_start. On that edge (E0), snapshot sec and min into two double-dabble shift registers and clear the iteration count.
  - CONV: one add-3-if-≥5 then shift-left per cycle, applied to both values in parallel. After 6 iterations (edges E1..E6) go to DONE.
  - DONE (edge E7): write 4 BCD digit registers {min_t, min_o, sec_t, sec_o}, then return to IDLE.
- frame_start while the FSM is not IDLE is ignored; REFRESH_DIV >= 3 guarantees this never occurs.
- Arithmetic: 6-bit binary gives 2 BCD digits, tens 0..6. Inputs 60..63 display as "60".."63" and are not clamped.
- Digit mapping by index: 0 = sec_o, 1 = sec_t, 2 = min_o, 3 = min_t. No leading-zero suppression.
- Segment patterns (active-high) for 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
- Polarity: SEG_ACTIVE_LOW inverts an, seg and dp.
- Outputs are registered, with 1-cycle latency from index/digit registers to pins.
  - Exactly one an bit is active at a time, unless blank is high.
- blank high: an all inactive, seg all off, dp off on the next edge. Refresh counter, index and FSM continue. Deasserting blank resumes with the current index on the next edge.
- Reset (any cycle, including mid-CONV):
  - refresh count 0, index 0, FSM IDLE, shift registers 0, digit registers 0 (display reads 00.00);
  - an all inactive, seg all off, dp off;
  - an in-progress conversion is aborted and never written.
- After reset, digit 0 is driven from the first edge with reset low. The first real conversion happens at the first frame_start.

Decomposition:
- Shared package time_disp_pkg holds:
  - the FSM state enum (IDLE/CONV/DONE);
  - SEG_DIGIT[0..9] pattern constants and SEG_BLANK;
  - BCD iteration count constant 6;
  - digit index constants.
- One sub-module: seg7_decode, a combinational 4-bit BCD to 7-bit active-high pattern decoder. Polarity is applied in the top level.

Test Plan (REFRESH_DIV=4, SEG_ACTIVE_LOW=1):
- Reset held 3 cycles -> an=1111, seg=7F, dp=1 throughout. First cycle after release -> an=1110, seg=40 (digit "0").
- sec=37, min=12 held through one frame + 8 cycles -> sequence an=1110/seg=78, an=1101/seg=30, an=1011/seg=24/dp=0, an=0111/seg=79. Each pair is held 4 cycles.
- sec changes 37 -> 38 mid-frame -> ones digit stays 78 until 8 edges after the next frame_start, then shows 00 ("8").
- sec=63, min=59 -> digits sec_o=3 (30), sec_t=6 (02), min_o=9 (10), min_t=5 (12).
- blank pulsed for 5 cycles -> an=1111 the edge after assertion. Index keeps advancing, and the correct digit reappears the edge after deassertion.
- Reset asserted at edge E3 of a conversion of sec=45 -> digit registers read 0. The next frame displays the then-current inputs, with no partial 45 digits ever visible.
